// File: rtl/ap_mult_err_acc.sv
// ap_mult_err_acc: streaming error statistics for an approximate multiplier under test
module ap_mult_err_acc #(
  parameter int DW    = 8,
  parameter int CNT_W = 17,
  parameter int SUM_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     muld,
  input  logic [DW-1:0]     mulr,
  input  logic [2*DW-1:0]   ap_res,
  input  logic              in_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [SUM_W-1:0]  sum_ed,
  output logic [2*DW-1:0]   max_ed
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int AW = (SUM_W > 2*DW ? SUM_W : 2*DW) + 1;
  state_t state, state_n;
  logic v1, accept, go;
  logic [2*DW-1:0] exact, ap, ed;
  logic [AW-1:0] sum_full;
  assign in_ready = state == RUN;
  assign busy     = state == RUN || state == DRAIN;
  assign done     = state == DONE;
  assign accept   = in_valid && in_ready;
  assign go       = start && (state == IDLE || state == DONE);
  assign ed       = exact >= ap ? exact - ap : ap - exact;
  // widened so the saturation test sees the true carry even when ed is wider than the sum
  assign sum_full = AW'(sum_ed) + AW'(ed);
  always_comb begin
    state_n = state;
    state_n = go ? RUN :
              (state == RUN && accept && in_last) ? DRAIN :
              state == DRAIN ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      v1         <= 1'b0;
      exact      <= '0;
      ap         <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
      max_ed     <= '0;
    end else begin
      state <= state_n;
      v1    <= accept && !go;
      if (accept) begin
        exact <= {{DW{1'b0}}, muld} * {{DW{1'b0}}, mulr};
        ap    <= ap_res;
      end
      if (go) begin
        sample_cnt <= '0;
        err_cnt    <= '0;
        sum_ed     <= '0;
        max_ed     <= '0;
      end else if (v1) begin
        sample_cnt <= &sample_cnt ? sample_cnt : sample_cnt + CNT_W'(1);
        err_cnt    <= (ed != '0 && !(&err_cnt)) ? err_cnt + CNT_W'(1) : err_cnt;
        sum_ed     <= sum_full > AW'({SUM_W{1'b1}}) ? {SUM_W{1'b1}} : sum_full[SUM_W-1:0];
        max_ed     <= ed > max_ed ? ed : max_ed;
      end
    end
  end
endmodule
